adder_arbiter: RTL
==================

# adder_arbiter

Round-robin scheduler that shares one handshaked floating-point `adder` instance among `NUM_REQ` requesters, such as several column-accumulation engines in the coprocessor.
- Each requester submits an operand pair and receives the sum on a private response handshake.
- The block owns every strobe and ack of the adder's `input_a`/`input_b`/`output_z` handshake.
- Exactly one operation is in flight at a time.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16); `IDX_W = $clog2(NUM_REQ)`
- `cell_width`, 32, operand/result width
- `TIMEOUT`, 64, adder watchdog limit in cycles (used only with `ARB_TIMEOUT_EN`)
- `in_clk` in 1: clock, rising edge.
- `in_reset` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: per-requester request; held until that requester's `req_ready` is seen.
- `req_a`, `req_b` in NUM_REQ*cell_width: operands, slice i = `[i*cell_width +: cell_width]`.
- `req_ready` out NUM_REQ: one-cycle grant pulse; operands captured.
- `resp_valid` out NUM_REQ: result available for requester i.
- `resp_z` out cell_width: result, shared by all requesters.
- `resp_err` out 1: result invalid (watchdog expiry); qualified by `resp_valid`.
- `resp_ack` in NUM_REQ: requester consumed the response.
- `add_a`, `add_b` out cell_width: adder operands.
- `add_a_stb`, `add_b_stb`, `add_z_ack`, `add_rst` out 1: adder handshake and reset.
- `add_z` in cell_width: adder result.
- `add_z_stb`, `add_a_ack`, `add_b_ack` in 1: adder handshake.

## Operation
- Reset values:
  - `req_ready`, `resp_valid` = 0; `resp_z`, `add_a`, `add_b` = 0.
  - All strobes/acks = 0; `resp_err` = 0; `add_rst` = 1.
  - Pointer `ptr` = 0; state IDLE.
- `add_rst` deasserts on the first clock edge after `in_reset` rises. It is reasserted for exactly one cycle only on watchdog expiry.
- States:
  - **IDLE**:
    - Search `req_valid` starting at `ptr` and wrapping modulo NUM_REQ; first hit becomes `owner`.
    - Latch that requester's operands into `add_a`/`add_b`.
    - Pulse `req_ready[owner]`, raise both strobes, go to ISSUE.
    - No valid request: stay in IDLE.
  - **ISSUE**:
    - `add_a_stb` drops on the edge after `add_a_ack` is seen; `add_b_stb` independently on `add_b_ack`.
    - Acks may arrive in the same or different cycles.
    - When both have been seen, go to WAIT.
  - **WAIT**: on `add_z_stb`:
    - capture `add_z` into `resp_z`;
    - pulse `add_z_ack` for one cycle;
    - assert `resp_valid[owner]`;
    - go to RESP.
  - **RESP**:
    - Hold `resp_valid[owner]` and `resp_z` until `resp_ack[owner]` is sampled high.
    - Then clear `resp_valid`, set `ptr = (owner+1) mod NUM_REQ`, go to IDLE.
    - `resp_ack` bits of non-owners are ignored.
- At most one bit of `req_ready`/`resp_valid` is high at any time.
- Operands pass through unmodified. `resp_z` is the raw adder output; no width conversion.
- `in_reset` low in any state aborts immediately to reset values. The in-flight result is discarded and `add_rst`=1 clears the adder.

## Timing
- Grant latency: with state IDLE and `req_valid[i]` high at edge n, `req_ready[i]`, `add_a_stb` and `add_b_stb` are high in cycle n+1.
- A requester must drop or change `req_valid` only after seeing `req_ready`. A `req_valid` still high in the cycle after `req_ready` is a new request.
- `add_z_stb` seen at edge k: `add_z_ack`, `resp_valid[owner]` and `resp_z` are valid from cycle k+1.
- `resp_ack` seen at edge m: `resp_valid` is low from m+1; the earliest next grant is at edge m+1, visible in m+2.
- Fairness: a continuously requesting requester is granted within NUM_REQ grants.

## Configuration
- `ARB_TIMEOUT_EN` defined:
  - A counter runs in ISSUE and WAIT, cleared on entry to ISSUE.
  - When it reaches `TIMEOUT`: pulse `add_rst` for one cycle, drop both strobes, set `resp_err`=1 and `resp_z`=0, assert `resp_valid[owner]`, go to RESP.
  - `resp_err` clears when the response is acked.
- `ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT blocks indefinitely.
  - `resp_err` is tied to 0.

## Test plan
- Single request, NUM_REQ=4: requester 2 sends a=0x3F800000, b=0x40000000 with a behavioural adder of 3-cycle latency. Required: `req_ready[2]` one cycle after valid; `resp_valid[2]` with `resp_z`=0x40400000; `resp_err`=0.
- All four requesters valid simultaneously from reset, acking immediately. Required: grant order 0,1,2,3; requester 0 re-requesting is served again only after 3.
- Adder asserts `add_b_ack` 4 cycles after `add_a_ack`. Required: `add_a_stb` low while `add_b_stb` stays high until its ack; exactly one operation issued.
- `resp_ack[1]` delayed 5 cycles while requester 3 is valid. Required: `resp_valid[1]`/`resp_z` stable for 5 cycles, `req_ready[3]` only after the ack, non-owner `resp_ack` ignored.
- `in_reset` pulsed low during WAIT. Required: all outputs at reset values, `add_rst`=1, the late `add_z_stb` is ignored, and the next grant starts from requester 0.
- With `ARB_TIMEOUT_EN` and TIMEOUT=64, the adder never strobes. Required: `add_rst` pulse, `resp_valid[owner]` with `resp_err`=1 and `resp_z`=0 at cycle 64 after ISSUE entry.

Source files
------------

// File: rtl/adder_arbiter_if.sv
// Requester-side and adder-side handshake bundle for adder_arbiter.
// master: the arbiter; slave: requesters plus the shared adder.
interface adder_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned cell_width = 32
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*cell_width-1:0] req_a;
  logic [NUM_REQ*cell_width-1:0] req_b;
  logic [NUM_REQ-1:0]            resp_valid;
  logic [NUM_REQ-1:0]            resp_ack;
  logic [cell_width-1:0]         resp_z;
  logic                          resp_err;
  logic [cell_width-1:0]         add_a;
  logic [cell_width-1:0]         add_b;
  logic [cell_width-1:0]         add_z;
  logic                          add_a_stb;
  logic                          add_b_stb;
  logic                          add_z_ack;
  logic                          add_rst;
  logic                          add_z_stb;
  logic                          add_a_ack;
  logic                          add_b_ack;

  modport master (
    input  req_valid, req_a, req_b, resp_ack, add_z, add_z_stb, add_a_ack, add_b_ack,
    output req_ready, resp_valid, resp_z, resp_err, add_a, add_b, add_a_stb, add_b_stb,
           add_z_ack, add_rst
  );

  modport slave (
    output req_valid, req_a, req_b, resp_ack, add_z, add_z_stb, add_a_ack, add_b_ack,
    input  req_ready, resp_valid, resp_z, resp_err, add_a, add_b, add_a_stb, add_b_stb,
           add_z_ack, add_rst
  );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin sharing of one handshaked adder among NUM_REQ requesters, one op in flight.
// Optional adder watchdog enabled by defining ARB_TIMEOUT_EN.
module adder_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned cell_width = 32,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic            in_clk,
  input  logic            in_reset,
  adder_arbiter_if.master bus
);
  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q;
  logic [IDX_W-1:0]      ptr_q, owner_q, ptr_next;
  logic [IDX_W-1:0]      grant_idx, cand;
  logic [IDX_W:0]        sum;
  logic                  found;
  logic [NUM_REQ-1:0]    grant_oh, owner_oh;
  logic [NUM_REQ-1:0]    req_ready_q, resp_valid_q;
  logic [cell_width-1:0] resp_z_q, add_a_q, add_b_q, sel_a, sel_b;
  logic                  a_stb_q, b_stb_q, z_ack_q, add_rst_q;
  logic                  a_done, b_done;

  // First valid requester at or after ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    sum       = '0;
    cand      = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum  = {1'b0, ptr_q} + (IDX_W+1)'(k);
      cand = (sum >= (IDX_W+1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ)) : sum[IDX_W-1:0];
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a = bus.req_a[i*cell_width +: cell_width];
        sel_b = bus.req_b[i*cell_width +: cell_width];
      end
    end
  end

  assign grant_oh = NUM_REQ'(1) << grant_idx;
  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign ptr_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // A strobe that is already low means its ack was taken earlier.
  assign a_done   = !a_stb_q || bus.add_a_ack;
  assign b_done   = !b_stb_q || bus.add_b_ack;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             resp_err_q;
`endif

  always_ff @(posedge in_clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q      <= StIdle;
      ptr_q        <= '0;
      owner_q      <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_z_q     <= '0;
      add_a_q      <= '0;
      add_b_q      <= '0;
      a_stb_q      <= 1'b0;
      b_stb_q      <= 1'b0;
      z_ack_q      <= 1'b0;
      add_rst_q    <= 1'b1;
`ifdef ARB_TIMEOUT_EN
      cnt_q        <= '0;
      resp_err_q   <= 1'b0;
`endif
    end else begin
      add_rst_q   <= 1'b0;
      req_ready_q <= '0;
      z_ack_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (found) begin
            owner_q     <= grant_idx;
            add_a_q     <= sel_a;
            add_b_q     <= sel_b;
            req_ready_q <= grant_oh;
            a_stb_q     <= 1'b1;
            b_stb_q     <= 1'b1;
            state_q     <= StIssue;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        StIssue: begin
          if (bus.add_a_ack) a_stb_q <= 1'b0;
          if (bus.add_b_ack) b_stb_q <= 1'b0;
          if (a_done && b_done) state_q <= StWait;
        end
        StWait: begin
          if (bus.add_z_stb) begin
            resp_z_q     <= bus.add_z;
            z_ack_q      <= 1'b1;
            resp_valid_q <= owner_oh;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (bus.resp_ack[owner_q]) begin
            resp_valid_q <= '0;
            ptr_q        <= ptr_next;
            state_q      <= StIdle;
`ifdef ARB_TIMEOUT_EN
            resp_err_q   <= 1'b0;
`endif
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef ARB_TIMEOUT_EN
      // A real result arriving on the expiry edge wins over the watchdog.
      if (state_q == StIssue || state_q == StWait) begin
        if (cnt_q == CNT_W'(TIMEOUT - 1) && !(state_q == StWait && bus.add_z_stb)) begin
          add_rst_q    <= 1'b1;
          a_stb_q      <= 1'b0;
          b_stb_q      <= 1'b0;
          resp_err_q   <= 1'b1;
          resp_z_q     <= '0;
          resp_valid_q <= owner_oh;
          state_q      <= StResp;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
`endif
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_z     = resp_z_q;
  assign bus.add_a      = add_a_q;
  assign bus.add_b      = add_b_q;
  assign bus.add_a_stb  = a_stb_q;
  assign bus.add_b_stb  = b_stb_q;
  assign bus.add_z_ack  = z_ack_q;
  assign bus.add_rst    = add_rst_q;

`ifdef ARB_TIMEOUT_EN
  assign bus.resp_err = resp_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus.resp_err   = 1'b0;
`endif
endmodule
